serial_subtractor_8_bit: RTL
============================

// Module: serial_subtractor_8_bit
// PURPOSE
//   Bit-serial subtractor: computes d = a - b - b_in one bit per clock, LSB first.
//   Reverse-direction companion to the 8-bit ripple adder; built from the
//   same gate-level half/full-subtractor cell style.
//   Trades WIDTH cycles of latency for a single full-subtractor cell and a borrow flop.
//   Used by the lab datapath wherever a multi-cycle difference with a start/done handshake is acceptable.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//   clk    input   1      rising-edge clock
//   reset  input   1      synchronous, active-high reset
//   start  input   1      request; sampled only when ready (IDLE or DONE)
//   a      input   WIDTH  minuend, captured on accepted start
//   b      input   WIDTH  subtrahend, captured on accepted start
//   b_in   input   1      borrow-in, captured on accepted start
//   busy   output  1      high while bits are being processed
//   done   output  1      one-cycle pulse: d/b_out valid
//   d      output  WIDTH  difference; holds last result until next done
//   b_out  output  1      borrow-out (1 = a < b + b_in, unsigned)
// BEHAVIOUR
//   - One clock, clk; reset synchronous, active-high. Reset dominates every other input.
//   - Reset values: busy=0, done=0, d=0, b_out=0; state=IDLE; counter=0; borrow flop=0.
//   - States: IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE : start=1 accepted -> latch a, b into shift regs, borrow<=b_in, cnt<=0, go SHIFT.
//     SHIFT: per cycle bit i=cnt: diff_i = a_i ^ b_i ^ bw;
//            bw' = (~a_i & b_i) | (~(a_i ^ b_i) & bw); shift diff_i into MSB of the
//            internal result reg; cnt++. After bit WIDTH-1 go DONE.
//     DONE : d<=internal result, b_out<=final bw, done=1 for exactly this cycle.
//            If start=1 here it is accepted (same as IDLE) and next state is SHIFT;
//            otherwise next state is IDLE.
//   - Timing: start accepted at edge of cycle 0 -> busy=1 cycles 1..WIDTH,
//     done=1 in cycle WIDTH+1 (busy=0 there). Back-to-back throughput: one result per WIDTH+1 cycles.
//   - start while busy (SHIFT) is ignored; operands are not re-latched.
//   - a/b/b_in may change freely after acceptance; they do not affect the running op.
//   - d/b_out change only on DONE (or on reset); never show partial results.
//   - Arithmetic is modulo 2^WIDTH; b_out is the true borrow out of the MSB.
//   - Reset mid-operation: aborts; no done pulse; outputs return to reset values next cycle.
//   - Counter width $clog2(WIDTH); no wrap beyond WIDTH-1.
// CONFIGURATION
//   SUB_OVF_EN defined: adds output port ovf (1 bit), updated with d on DONE, reset 0;
//     ovf = signed (two's-complement) overflow of a - b - b_in:
//     (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).
//   SUB_OVF_EN undefined: no ovf port, no overflow logic; all else identical.
// TESTING
//   1. reset 2 cycles; a=29,b=5,b_in=0, start 1 cycle -> busy cycles 1..8, done in cycle 9, d=24, b_out=0.
//   2. a=5,b=29,b_in=0 -> d=232 (8'hE8), b_out=1.
//   3. a=0,b=0,b_in=1 -> d=255, b_out=1; a=200,b=95,b_in=1 -> d=104, b_out=0.
//   4. start=1 held through SHIFT with operands changed to a=1,b=1 -> ignored; first result
//      from originally latched pair; start still high in DONE -> second op accepted, done 9 cycles later.
//   5. reset asserted in cycle 4 of an op -> no done pulse; busy=0, d=0, b_out=0 next cycle; fresh op then correct.
//   6. SUB_OVF_EN: a=128,b=1 -> d=127, ovf=1; a=51,b=92 -> d=215, ovf=0, b_out=1.

Source files
------------

// File: rtl/serial_subtractor_8_bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8_bit
//   Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first.
//   A single gate-level full-subtractor cell plus a borrow flop does all the
//   arithmetic. The operands are held in shift registers, and the difference
//   bits are shifted into a result register from the MSB end.
//
//   Handshake: start is accepted in IDLE or DONE. busy is high for WIDTH
//   cycles. done pulses for one cycle, and d/b_out are valid in that cycle.
//   Back-to-back throughput is one result every WIDTH+1 cycles.
//
//   Optional feature (macro SUB_OVF_EN): adds the output ovf. This is the
//   two's-complement overflow of a - b - b_in, updated together with d.
// ---------------------------------------------------------------------------

// Half subtractor: diff = x - y, borrow when x < y.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic diff,
   output logic borrow
);
   assign diff   = x ^ y;
   assign borrow = ~x & y;
endmodule

// Full subtractor from two half subtractors:
//   diff   = x ^ y ^ bw
//   borrow = (~x & y) | (~(x ^ y) & bw)
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bw,
   output logic diff,
   output logic borrow
);
   logic d1, b1, b2;

   half_subtractor hs_xy (
      .x      (x),
      .y      (y),
      .diff   (d1),
      .borrow (b1)
   );

   half_subtractor hs_bw (
      .x      (d1),
      .y      (bw),
      .diff   (diff),
      .borrow (b2)
   );

   assign borrow = b1 | b2;
endmodule

module serial_subtractor_8_bit #(
   parameter int WIDTH = 8               // legal range 2..32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;       // index of the bit being processed
   logic [WIDTH-1:0] a_sr;      // minuend, bit 0 is the current bit
   logic [WIDTH-1:0] b_sr;      // subtrahend, bit 0 is the current bit
   logic [WIDTH-1:0] res;       // partial difference, filled from the MSB end
   logic             bw_q;      // running borrow between bit positions

   logic             diff_bit;
   logic             bw_next;

   // The only arithmetic in the datapath: one bit of a - b - borrow.
   full_subtractor u_cell (
      .x      (a_sr[0]),
      .y      (b_sr[0]),
      .bw     (bw_q),
      .diff   (diff_bit),
      .borrow (bw_next)
   );

   // Sequencer and datapath. All outputs are registered, so d/b_out move only
   // on the edge that raises done.
   // NOTE: every register here, including the operand and result shift
   // registers, is cleared on reset. An aborted operation then leaves no
   // stale partial bits behind, and the outputs come out of reset at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         b_out <= 1'b0;
         cnt   <= '0;
         bw_q  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         res   <= '0;
`ifdef SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout. Every right-hand side
         // reads the pre-edge value, so the shift registers, the borrow and
         // the counter all advance together without ordering hazards.
         case (state)
            IDLE, DONE: begin
               // done is a one-cycle pulse, and a new request may be taken
               // straight out of DONE for back-to-back operation.
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  bw_q  <= b_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end

            SHIFT: begin
               // start is ignored here, and the latched operands are the only
               // inputs to the arithmetic.
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               res  <= {diff_bit, res[WIDTH-1:1]};
               bw_q <= bw_next;
               if (cnt == LAST_BIT) begin
                  // The last bit goes straight to the output register. The
                  // borrow out of the MSB is the true borrow of the operation.
                  d     <= {diff_bit, res[WIDTH-1:1]};
                  b_out <= bw_next;
`ifdef SUB_OVF_EN
                  // At this point a_sr[0]/b_sr[0] hold the operand MSBs and
                  // diff_bit is the result MSB.
                  ovf   <= (a_sr[0] ^ b_sr[0]) & (diff_bit ^ a_sr[0]);
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
